// File: rtl/fetch_decode_stage.sv
// Instruction fetch plus the F/D pipeline register.
// Holds the PC on stall, redirects from decode, and inserts bubbles.
module fetch_decode_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          PC_STEP     = 4,
   parameter int          STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   f_stall,
   input  logic                   d_stall,
   input  logic                   d_pc_src,
   input  logic [31:0]            d_target,
   input  logic [31:0]            imem_rdata,
   output logic [31:0]            imem_addr,
   output logic [31:0]            f_pc,
   output logic [31:0]            d_instr,
   output logic [31:0]            d_pc_plus4,
   output logic                   d_valid,
   output logic                   misalign_err,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam logic [31:0] STEP = 32'(PC_STEP);

   logic        hold_f;
   logic        redirect;
   logic        tgt_misaligned;
   logic [31:0] tgt;
   logic [31:0] pc_seq;
   logic        cnt_sat;

   assign hold_f         = f_stall | d_stall;
   assign redirect       = d_pc_src & ~hold_f;
   assign tgt            = {d_target[31:2], 2'b00};
   assign tgt_misaligned = d_target[1:0] != 2'b00;
   assign pc_seq         = f_pc + STEP;
   assign cnt_sat        = &stall_count;
   assign imem_addr      = f_pc;

   // PC: a decode stall also freezes fetch so nothing is dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         f_pc <= RESET_PC;
      end else if (hold_f) begin
         f_pc <= f_pc;
      end else if (d_pc_src) begin
         f_pc <= tgt;
      end else begin
         f_pc <= pc_seq;
      end
   end

   // F/D: a stalled decode keeps its instruction and ignores its redirect
   always_ff @(posedge clk) begin
      if (reset) begin
         d_instr    <= '0;
         d_pc_plus4 <= '0;
         d_valid    <= 1'b0;
      end else if (d_stall) begin
         d_instr    <= d_instr;
         d_pc_plus4 <= d_pc_plus4;
         d_valid    <= d_valid;
      end else if (d_pc_src || f_stall) begin
         d_instr    <= '0;
         d_pc_plus4 <= '0;
         d_valid    <= 1'b0;
      end else begin
         d_instr    <= imem_rdata;
         d_pc_plus4 <= pc_seq;
         d_valid    <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_err <= 1'b0;
      end else if (redirect && tgt_misaligned) begin
         misalign_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (hold_f && !cnt_sat) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed table, random run against
// a reference model, and stall-counter saturation.
module tb_fetch_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        f_stall;
   logic        d_stall;
   logic        d_pc_src;
   logic [31:0] d_target;
   logic [31:0] imem_rdata;
   logic [31:0] imem_addr;
   logic [31:0] f_pc;
   logic [31:0] d_instr;
   logic [31:0] d_pc_plus4;
   logic        d_valid;
   logic        misalign_err;
   logic [15:0] stall_count;

   int n_vec  = 0;
   int n_fail = 0;

   fetch_decode_stage dut (
      .clk          (clk),
      .reset        (reset),
      .f_stall      (f_stall),
      .d_stall      (d_stall),
      .d_pc_src     (d_pc_src),
      .d_target     (d_target),
      .imem_rdata   (imem_rdata),
      .imem_addr    (imem_addr),
      .f_pc         (f_pc),
      .d_instr      (d_instr),
      .d_pc_plus4   (d_pc_plus4),
      .d_valid      (d_valid),
      .misalign_err (misalign_err),
      .stall_count  (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, fs, ds, src;
      logic [31:0] tgt, rdata;
      logic [31:0] e_pc, e_instr, e_p4;
      logic        e_v, e_err;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[22];

   // reference model state
   logic [31:0] m_pc, m_instr, m_p4;
   logic        m_v, m_err;
   int          m_cnt;

   function automatic vec_t mk(
      logic r, logic fs, logic ds, logic src,
      logic [31:0] tgt, logic [31:0] rd,
      logic [31:0] pc, logic [31:0] ins, logic [31:0] p4,
      logic v, logic err, logic [15:0] cnt);
      vec_t t;
      t.rst = r; t.fs = fs; t.ds = ds; t.src = src;
      t.tgt = tgt; t.rdata = rd;
      t.e_pc = pc; t.e_instr = ins; t.e_p4 = p4;
      t.e_v = v; t.e_err = err; t.e_cnt = cnt;
      return t;
   endfunction

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check_all(string tag, logic [31:0] pc,
                            logic [31:0] ins, logic [31:0] p4,
                            logic v, logic err, logic [15:0] cnt);
      chk({tag, " imem_addr"}, imem_addr, pc);
      chk({tag, " f_pc"}, f_pc, pc);
      chk({tag, " d_instr"}, d_instr, ins);
      chk({tag, " d_pc_plus4"}, d_pc_plus4, p4);
      chk({tag, " d_valid"}, 32'(d_valid), 32'(v));
      chk({tag, " misalign_err"}, 32'(misalign_err), 32'(err));
      chk({tag, " stall_count"}, 32'(stall_count), 32'(cnt));
   endtask

   task automatic drive(logic r, logic fs, logic ds, logic src,
                        logic [31:0] tgt, logic [31:0] rd);
      reset      = r;
      f_stall    = fs;
      d_stall    = ds;
      d_pc_src   = src;
      d_target   = tgt;
      imem_rdata = rd;
   endtask

   // Next state from the behavioural rules, using current inputs.
   task automatic model_step();
      logic        stall_any;
      logic [31:0] seq;
      stall_any = f_stall | d_stall;
      seq = m_pc + 32'd4;
      if (reset) begin
         m_pc = 32'h0; m_instr = 0; m_p4 = 0;
         m_v = 0; m_err = 0; m_cnt = 0;
         return;
      end
      if (d_pc_src && !stall_any && (d_target % 4 != 0))
         m_err = 1'b1;
      if (!d_stall) begin
         if (d_pc_src || f_stall) begin
            m_instr = 0; m_p4 = 0; m_v = 0;
         end else begin
            m_instr = imem_rdata; m_p4 = seq; m_v = 1;
         end
      end
      if (!stall_any)
         m_pc = d_pc_src ? (d_target / 4) * 4 : seq;
      if (stall_any && m_cnt < 65535)
         m_cnt = m_cnt + 1;
   endtask

   task automatic check_model(string tag);
      check_all(tag, m_pc, m_instr, m_p4, m_v, m_err, 16'(m_cnt));
   endtask

   initial begin
      logic r, fs, ds, src;
      logic [31:0] tg;

      // rst fs ds src  tgt  rdata  | pc instr p4 v err cnt
      tbl[0]  = mk(1,0,0,0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0,0,0,0, 0, 32'h2008_0005,
                   32'h4, 32'h2008_0005, 32'h4, 1, 0, 0);
      tbl[2]  = mk(0,0,0,0, 0, 32'h2008_0005,
                   32'h8, 32'h2008_0005, 32'h8, 1, 0, 0);
      tbl[3]  = mk(0,0,0,0, 0, 32'h2008_0005,
                   32'hC, 32'h2008_0005, 32'hC, 1, 0, 0);
      tbl[4]  = mk(0,0,0,0, 0, 32'h1111_1111,
                   32'h10, 32'h1111_1111, 32'h10, 1, 0, 0);
      tbl[5]  = mk(0,1,1,0, 0, 32'h2222_2222,
                   32'h10, 32'h1111_1111, 32'h10, 1, 0, 1);
      tbl[6]  = mk(0,1,1,0, 0, 32'h2222_2222,
                   32'h10, 32'h1111_1111, 32'h10, 1, 0, 2);
      tbl[7]  = mk(0,0,0,0, 0, 32'h2222_2222,
                   32'h14, 32'h2222_2222, 32'h14, 1, 0, 2);
      tbl[8]  = mk(0,0,0,1, 32'h400, 32'h3333_3333,
                   32'h400, 0, 0, 0, 0, 2);
      tbl[9]  = mk(0,0,0,0, 0, 32'h4444_4444,
                   32'h404, 32'h4444_4444, 32'h404, 1, 0, 2);
      tbl[10] = mk(0,1,1,1, 32'h800, 32'h9999_9999,
                   32'h404, 32'h4444_4444, 32'h404, 1, 0, 3);
      tbl[11] = mk(0,0,0,1, 32'h800, 32'h9999_9999,
                   32'h800, 0, 0, 0, 0, 3);
      tbl[12] = mk(0,1,0,0, 0, 32'h5555_5555,
                   32'h800, 0, 0, 0, 0, 4);
      tbl[13] = mk(0,0,0,0, 0, 32'h5555_5555,
                   32'h804, 32'h5555_5555, 32'h804, 1, 0, 4);
      tbl[14] = mk(0,0,0,1, 32'h403, 32'hAAAA_AAAA,
                   32'h400, 0, 0, 0, 1, 4);
      tbl[15] = mk(0,0,0,0, 0, 32'h6666_6666,
                   32'h404, 32'h6666_6666, 32'h404, 1, 1, 4);
      tbl[16] = mk(0,0,0,1, 32'hFFFF_FFFD, 32'hBBBB_BBBB,
                   32'hFFFF_FFFC, 0, 0, 0, 1, 4);
      tbl[17] = mk(0,0,0,0, 0, 32'h7777_7777,
                   32'h0, 32'h7777_7777, 32'h0, 1, 1, 4);
      tbl[18] = mk(0,1,1,0, 0, 32'hCCCC_CCCC,
                   32'h0, 32'h7777_7777, 32'h0, 1, 1, 5);
      tbl[19] = mk(1,1,1,1, 32'h123, 32'hCCCC_CCCC,
                   32'h0, 0, 0, 0, 0, 0);
      tbl[20] = mk(0,0,1,1, 32'h13, 32'hDDDD_DDDD,
                   32'h0, 0, 0, 0, 0, 1);
      tbl[21] = mk(0,0,0,0, 0, 32'h8888_8888,
                   32'h4, 32'h8888_8888, 32'h4, 1, 0, 1);

      drive(1, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].rst, tbl[i].fs, tbl[i].ds, tbl[i].src,
               tbl[i].tgt, tbl[i].rdata);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), tbl[i].e_pc,
                   tbl[i].e_instr, tbl[i].e_p4, tbl[i].e_v,
                   tbl[i].e_err, tbl[i].e_cnt);
      end

      // random run against the reference model
      drive(1, 0, 0, 0, 0, 0);
      model_step();
      @(posedge clk);
      #1;
      check_model("rnd_reset");
      for (int i = 0; i < 2000; i++) begin
         r   = $urandom_range(99) == 0;
         fs  = $urandom_range(4) == 0;
         ds  = $urandom_range(4) == 0;
         src = $urandom_range(6) == 0;
         case ($urandom_range(7))
            0:       tg = 32'hFFFF_FFFC;
            1:       tg = $urandom;
            default: tg = $urandom & 32'hFFFF_FFFC;
         endcase
         drive(r, fs, ds, src, tg, mem_word(m_pc));
         model_step();
         @(posedge clk);
         #1;
         check_model($sformatf("rnd%0d", i));
      end

      // stall counter saturation
      drive(1, 0, 0, 0, 0, 0);
      model_step();
      @(posedge clk);
      #1;
      check_model("sat_reset");
      for (int i = 0; i < 65536; i++) begin
         drive(0, 1, 0, 0, 0, mem_word(m_pc));
         model_step();
         @(posedge clk);
      end
      #1;
      chk("sat_count", 32'(stall_count), 32'h0000_FFFF);
      check_model("sat_model");
      drive(0, 0, 1, 0, 0, mem_word(m_pc));
      model_step();
      @(posedge clk);
      #1;
      chk("sat_nowrap", 32'(stall_count), 32'h0000_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Instruction-fetch stage plus the F/D pipeline register of the 5-stage MIPS pipeline.
- Directly consumes the hazard controller's `f_stall`/`d_stall` outputs and the branch/jump redirect resolved in decode.
- Drives the instruction-memory address and feeds decode with the instruction, PC+4 and a valid bit.
- Also keeps a sticky misaligned-redirect flag and a saturating stall-cycle counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  pipeline clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- f_stall  input  1  hold the PC (from hazard controller).
- d_stall  input  1  hold the F/D register (from hazard controller).
- d_pc_src  input  1  decode resolved a taken branch/jump this cycle.
- d_target  input  32  redirect target address.
- imem_rdata  input  32  instruction word at imem_addr (combinational memory).
- imem_addr  output  32  fetch address (= f_pc).
- f_pc  output  32  current PC register.
- d_instr  output  32  F/D instruction.
- d_pc_plus4  output  32  F/D PC+PC_STEP of that instruction.
- d_valid  output  1  F/D holds a real instruction.
- misalign_err  output  1  sticky: a redirect target had target[1:0] != 0.
- stall_count  output  STALL_CNT_W  saturating count of stalled cycles.

Behaviour:
- Decided: one clock, clk; reset is synchronous and active-high, port reset; no asynchronous logic anywhere.
- Reset values: f_pc = RESET_PC, d_instr = 0, d_pc_plus4 = 0, d_valid = 0, misalign_err = 0, stall_count = 0. A reset asserted mid-stall or mid-redirect overrides everything on that edge.
- imem_addr = f_pc combinationally, zero latency; fetch-to-decode latency is 1 cycle.
- Define hold_f = f_stall | d_stall. d_stall alone also freezes the PC so no instruction is lost.
- Aligned target: tgt = {d_target[31:2], 2'b00}.
- PC update, priority order per edge:
  - reset -> RESET_PC;
  - else hold_f -> hold;
  - else d_pc_src -> tgt;
  - else f_pc + PC_STEP, wrapping modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- F/D update, priority order per edge:
  - reset -> clear;
  - else d_stall -> hold all three fields, even if d_pc_src = 1 (a stalled decode's redirect is ignored and re-evaluated next cycle);
  - else d_pc_src -> bubble (d_instr = 0 i.e. sll nop, d_pc_plus4 = 0, d_valid = 0);
  - else f_stall -> bubble, so the held fetch is never duplicated;
  - else load d_instr = imem_rdata, d_pc_plus4 = f_pc + PC_STEP, d_valid = 1.
- No branch delay slot: the instruction fetched in the redirect cycle is squashed.
- misalign_err: set on any edge where d_pc_src & ~hold_f & (d_target[1:0] != 0). Cleared only by reset.
- stall_count: increments on each non-reset edge with hold_f = 1 and saturates at all-ones, with no wrap.
- The outputs are registers or a direct register copy (imem_addr), so there are no combinational input-to-output paths.

Test Plan:
- Reset then 3 free-run cycles with imem_rdata = 0x2008_0005 -> imem_addr 0, 4, 8, C; d_valid 0, 1, 1, 1; d_pc_plus4 = 4, 8, C; d_instr = 0x2008_0005.
- f_stall = d_stall = 1 for 2 cycles at f_pc = 0x10 -> f_pc stays 0x10, F/D fields frozen, stall_count = 2; on release the fetch resumes at 0x10 and no instruction is duplicated.
- d_pc_src = 1, d_target = 0x0000_0400, no stall -> next f_pc = 0x400, d_valid = 0, d_instr = 0; following cycle d_valid = 1 with d_pc_plus4 = 0x404.
- d_pc_src = 1 together with f_stall = d_stall = 1 -> PC and F/D hold; drop the stalls with d_pc_src still 1 -> redirect taken on that edge.
- f_stall = 1, d_stall = 0 -> PC held and a bubble is inserted (d_valid = 0); then d_pc_src with d_target = 0x403 -> f_pc = 0x400, misalign_err = 1 and it stays 1 until reset.
- f_pc = 0xFFFF_FFFC free-run -> next f_pc = 0. Assert reset during a stall -> f_pc = RESET_PC and stall_count = 0 on that edge. Hold stall for 65536 cycles -> stall_count = 0xFFFF.
